// File: rtl/wb_trace_fifo.sv
// wb_trace_fifo
// Retirement-trace buffer for the miniRV writeback debug stream.
// Each retired instruction is tagged with a sequence number and queued; a
// trace sink drains the queue through a valid/ready port. When the queue is
// full, the CPU is never stalled. Instead the record is dropped and counted.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   wb_have_inst             instruction retired this cycle
//   wb_pc/ena/reg/value      writeback debug fields of that instruction
//   out_valid/out_ready      head record handshake (pop = valid & ready)
//   out_seq/pc/ena/reg/value head record fields (zero when empty)
//   level, full, empty       registered occupancy status
//   drop_cnt, overflow       saturating drop counter and sticky drop flag
//   clr_overflow             clears drop_cnt/overflow
module wb_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_have_inst,
  input  logic [31:0]              wb_pc,
  input  logic                     wb_ena,
  input  logic [4:0]               wb_reg,
  input  logic [31:0]              wb_value,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CNT_W-1:0]         out_seq,
  output logic [31:0]              out_pc,
  output logic                     out_ena,
  output logic [4:0]               out_reg,
  output logic [31:0]              out_value,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic                     overflow,
  input  logic                     clr_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int RW = CNT_W + 32 + 1 + 5 + 32;

  logic [RW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] seq_next;
  logic [LW-1:0]    level_next;
  logic [RW-1:0]    rec_in;
  logic [RW-1:0]    head;
  logic             pop;
  logic             push_ok;
  logic             drop;
  logic             x0_write;

  assign pop     = !empty && out_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push_ok = wb_have_inst && (!full || pop);
  assign drop    = wb_have_inst && full && !pop;

  // Writes to x0 never take effect, so they are stored as "no write".
  assign x0_write = (wb_reg == 5'd0);
  assign rec_in   = {seq_next, wb_pc, wb_ena && !x0_write, wb_reg,
                     x0_write ? 32'd0 : wb_value};

  assign head      = empty ? '0 : mem[rd_ptr];
  assign out_valid = !empty;
  assign out_value = head[31:0];
  assign out_reg   = head[36:32];
  assign out_ena   = head[37];
  assign out_pc    = head[69:38];
  assign out_seq   = head[RW-1:70];

  always_comb begin
    level_next = level;
    if (push_ok && !pop)
      level_next = level + LW'(1);
    else if (!push_ok && pop)
      level_next = level - LW'(1);
  end

  // Storage carries no reset; stale entries are masked by empty.
  always_ff @(posedge clk) begin
    if (!rst && push_ok)
      mem[wr_ptr] <= rec_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      seq_next <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      level <= level_next;
      full  <= (level_next == LW'(DEPTH));
      empty <= (level_next == '0);
      // Sequence advances on every retire, stored or not, so gaps mark drops.
      if (wb_have_inst)
        seq_next <= seq_next + CNT_W'(1);
      if (clr_overflow) begin
        drop_cnt <= drop ? CNT_W'(1) : '0;
        overflow <= drop;
      end else if (drop) begin
        if (drop_cnt != {CNT_W{1'b1}})
          drop_cnt <= drop_cnt + CNT_W'(1);
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_trace_fifo.sv
module tb_wb_trace_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_have_inst;
  logic [31:0] wb_pc;
  logic        wb_ena;
  logic [4:0]  wb_reg;
  logic [31:0] wb_value;
  logic        out_ready;
  logic        clr_overflow;

  logic        out_valid, out_ena, full, empty, overflow;
  logic [15:0] out_seq, drop_cnt;
  logic [31:0] out_pc, out_value;
  logic [4:0]  out_reg;
  logic [4:0]  level;

  logic        v4, ena4, full4, empty4, ovf4;
  logic [3:0]  seq4, drop4;
  logic [31:0] pc4, val4;
  logic [4:0]  reg4;
  logic [4:0]  level4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_trace_fifo #(.DEPTH(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .wb_have_inst(wb_have_inst), .wb_pc(wb_pc),
    .wb_ena(wb_ena), .wb_reg(wb_reg), .wb_value(wb_value),
    .out_valid(out_valid), .out_ready(out_ready), .out_seq(out_seq),
    .out_pc(out_pc), .out_ena(out_ena), .out_reg(out_reg),
    .out_value(out_value), .level(level), .full(full), .empty(empty),
    .drop_cnt(drop_cnt), .overflow(overflow), .clr_overflow(clr_overflow)
  );

  wb_trace_fifo #(.DEPTH(16), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .wb_have_inst(wb_have_inst), .wb_pc(wb_pc),
    .wb_ena(wb_ena), .wb_reg(wb_reg), .wb_value(wb_value),
    .out_valid(v4), .out_ready(out_ready), .out_seq(seq4),
    .out_pc(pc4), .out_ena(ena4), .out_reg(reg4),
    .out_value(val4), .level(level4), .full(full4), .empty(empty4),
    .drop_cnt(drop4), .overflow(ovf4), .clr_overflow(clr_overflow)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [31:0] pc, input logic ena,
                        input logic [4:0] rg, input logic [31:0] val);
    wb_have_inst = 1'b1;
    wb_pc = pc; wb_ena = ena; wb_reg = rg; wb_value = val;
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b0; clr_overflow = 1'b0;
    retire(32'h100, 1'b1, 5'd3, 32'h55);

    // Reset held two cycles with a retire present
    tick(); tick();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_pc", 64'(out_pc), 64'd0);
    chk("rst_seq", 64'(out_seq), 64'd0);

    // Single record
    rst = 1'b0;
    retire(32'h0000_0004, 1'b1, 5'd5, 32'h1234_5678);
    tick();
    wb_have_inst = 1'b0;
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_seq", 64'(out_seq), 64'd0);
    chk("single_pc", 64'(out_pc), 64'h4);
    chk("single_ena", 64'(out_ena), 64'd1);
    chk("single_reg", 64'(out_reg), 64'd5);
    chk("single_value", 64'(out_value), 64'h1234_5678);
    chk("single_level", 64'(level), 64'd1);
    tick();
    chk("single_hold_value", 64'(out_value), 64'h1234_5678);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("single_pop_empty", 64'(empty), 64'd1);
    chk("single_pop_valid", 64'(out_valid), 64'd0);
    chk("single_pop_pc", 64'(out_pc), 64'd0);

    // x0 normalisation
    retire(32'h8, 1'b1, 5'd0, 32'hDEAD_BEEF);
    tick();
    wb_have_inst = 1'b0;
    chk("x0_seq", 64'(out_seq), 64'd1);
    chk("x0_pc", 64'(out_pc), 64'h8);
    chk("x0_ena", 64'(out_ena), 64'd0);
    chk("x0_reg", 64'(out_reg), 64'd0);
    chk("x0_value", 64'(out_value), 64'd0);

    // Fill and overflow
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 19; i++) begin
      retire(32'(i * 4), 1'b1, 5'(i + 1), 32'(i));
      tick();
    end
    wb_have_inst = 1'b0;
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_level", 64'(level), 64'd16);
    chk("fill_drop", 64'(drop_cnt), 64'd3);
    chk("fill_ovf", 64'(overflow), 64'd1);
    chk("fill_drop4", 64'(drop4), 64'd3);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_seq", 64'(out_seq), 64'(i));
      chk("drain_pc", 64'(out_pc), 64'(i * 4));
      tick();
    end
    out_ready = 1'b0;
    chk("drain_empty", 64'(empty), 64'd1);
    retire(32'h400, 1'b1, 5'd7, 32'h77);
    tick();
    wb_have_inst = 1'b0;
    chk("after_drop_seq", 64'(out_seq), 64'd19);
    chk("after_drop_cnt", 64'(drop_cnt), 64'd3);

    // Full with simultaneous push and pop; clear coinciding with drop
    for (int i = 0; i < 15; i++) begin
      retire(32'(32'h1000 + i), 1'b0, 5'd1, 32'(i));
      tick();
    end
    chk("refill_full", 64'(full), 64'd1);
    retire(32'h2000, 1'b1, 5'd2, 32'h2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("pushpop_level", 64'(level), 64'd16);
    chk("pushpop_full", 64'(full), 64'd1);
    chk("pushpop_drop", 64'(drop_cnt), 64'd3);
    chk("pushpop_head", 64'(out_seq), 64'd20);
    clr_overflow = 1'b1;
    tick();
    wb_have_inst = 1'b0;
    chk("clr_drop_cnt", 64'(drop_cnt), 64'd1);
    chk("clr_drop_ovf", 64'(overflow), 64'd1);
    tick();
    clr_overflow = 1'b0;
    chk("clr_cnt", 64'(drop_cnt), 64'd0);
    chk("clr_ovf", 64'(overflow), 64'd0);

    // Sustained streaming with the sink always ready
    rst = 1'b1; tick(); rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      retire(32'(i), 1'b1, 5'd9, 32'(i + 1));
      tick();
      chk("stream_seq", 64'(out_seq), 64'(i));
      chk("stream_level", 64'(level), 64'd1);
      chk("stream_seq4", 64'(seq4), 64'(i % 16));
    end
    wb_have_inst = 1'b0;
    chk("stream_drop", 64'(drop_cnt), 64'd0);
    tick();
    chk("stream_end_empty", 64'(empty), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
